// File: rtl/cpuc_cmp_reduce_if.sv
// ---------------------------------------------------------------------------
// cpuc_cmp_reduce_if
// Stream bundle for the max/min frame reducer: an input beat stream
// (valid/ready/data/last plus the per-frame mode bit) and a result stream
// (valid/ready plus the extreme value, its index, the frame length and the
// overflow flag).
//   master : producer of beats and consumer of results (the CPUC side)
//   slave  : the reducer itself
// Parameters
//   DATA_WIDTH : word width
//   IDX_W      : index width, must equal $clog2(MAX_LEN) of the reducer
// ---------------------------------------------------------------------------
interface cpuc_cmp_reduce_if #(
    parameter int DATA_WIDTH = 32,
    parameter int IDX_W      = 8
);
    logic                  mode_min;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_last;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic [IDX_W-1:0]      out_idx;
    logic [IDX_W:0]        out_count;
    logic                  out_ovf;

    modport master (
        output mode_min, in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_idx, out_count, out_ovf
    );

    modport slave (
        input  mode_min, in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_idx, out_count, out_ovf
    );
endinterface

// File: rtl/cpuc_cmp_reduce.sv
// ---------------------------------------------------------------------------
// cpuc_cmp_reduce
// Streaming max/min reducer. Consumes a frame of words over a valid/ready
// stream and returns the extreme value of the frame, its 0-based position
// and the (saturating) frame length, with an overflow flag for frames longer
// than MAX_LEN beats. One beat per cycle, no bubble between frames while the
// result consumer is ready.
// Ports
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : cpuc_cmp_reduce_if.slave
//           in : mode_min, in_valid, in_data, in_last, out_ready
//           out: in_ready, out_valid, out_data, out_idx, out_count, out_ovf
// Parameters
//   DATA_WIDTH : word width
//   SIGNED_CMP : 1 two's-complement compare, 0 unsigned compare
//   MAX_LEN    : saturation length of the frame counter (>= 2)
// Configuration macro
//   CPUC_CMP_IDX_EN : when defined the winner-index register is built and
//                     out_idx reports the winner position; otherwise out_idx
//                     is tied to zero.
// ---------------------------------------------------------------------------
module cpuc_cmp_reduce #(
    parameter int DATA_WIDTH = 32,
    parameter int SIGNED_CMP = 1,
    parameter int MAX_LEN    = 256
) (
    input  logic               clk,
    input  logic               rst_n,
    cpuc_cmp_reduce_if.slave   bus
);
    localparam int IDX_W = $clog2(MAX_LEN);
    localparam int CW    = IDX_W + 1;
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_LEN);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t                state_r;
    state_t                state_next_s;

    // Accumulator doubles as the result register: it is only exposed as a
    // valid result in HOLD, where it cannot change until the result is taken.
    logic [DATA_WIDTH-1:0] acc_r;
    logic [CW-1:0]         count_r;
    logic                  ovf_r;
    logic                  mode_r;

    logic                  in_ready_s;
    logic                  out_valid_s;
    logic                  accept_s;
    logic                  start_s;
    logic                  gt_s;
    logic                  lt_s;
    logic                  replace_s;
    logic                  cnt_full_s;

    assign accept_s   = bus.in_valid & in_ready_s;
    // In HOLD in_ready mirrors out_ready, so any beat accepted outside ACC
    // also implies the pending result was taken: it always opens a new frame.
    assign start_s    = accept_s & (state_r != ST_ACC);
    assign cnt_full_s = (count_r == MAX_CNT);
    assign replace_s  = mode_r ? lt_s : gt_s;

    // Magnitude compare of the incoming beat against the running extreme.
    always_comb begin
        gt_s = 1'b0;
        lt_s = 1'b0;
        if (SIGNED_CMP != 0) begin
            gt_s = ($signed(bus.in_data) > $signed(acc_r));
            lt_s = ($signed(bus.in_data) < $signed(acc_r));
        end else begin
            gt_s = (bus.in_data > acc_r);
            lt_s = (bus.in_data < acc_r);
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_next_s = bus.in_last ? ST_HOLD : ST_ACC;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ACC: begin
                if (accept_s && bus.in_last) begin
                    state_next_s = ST_HOLD;
                end else begin
                    state_next_s = ST_ACC;
                end
            end
            ST_HOLD: begin
                if (out_valid_s && bus.out_ready) begin
                    if (accept_s) begin
                        state_next_s = bus.in_last ? ST_HOLD : ST_ACC;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end else begin
                    state_next_s = ST_HOLD;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // FSM outputs: handshake signals decoded from the state register.
    always_comb begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                in_ready_s  = 1'b1;
                out_valid_s = 1'b0;
            end
            ST_ACC: begin
                in_ready_s  = 1'b1;
                out_valid_s = 1'b0;
            end
            ST_HOLD: begin
                in_ready_s  = bus.out_ready;
                out_valid_s = 1'b1;
            end
            default: begin
                in_ready_s  = 1'b0;
                out_valid_s = 1'b0;
            end
        endcase
    end

    // Running extreme, saturating length, sticky overflow and latched mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r   <= {DATA_WIDTH{1'b0}};
            count_r <= {CW{1'b0}};
            ovf_r   <= 1'b0;
            mode_r  <= 1'b0;
        end else if (start_s) begin
            acc_r   <= bus.in_data;
            count_r <= CW'(1);
            ovf_r   <= 1'b0;
            mode_r  <= bus.mode_min;
        end else if (accept_s) begin
            if (replace_s) begin
                acc_r <= bus.in_data;
            end
            if (!cnt_full_s) begin
                count_r <= count_r + CW'(1);
            end
            // A beat arriving with the counter already at MAX_LEN is one too many.
            ovf_r <= ovf_r | cnt_full_s;
        end
    end

`ifdef CPUC_CMP_IDX_EN
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(MAX_LEN - 1);

    logic [IDX_W-1:0] idx_r;

    // Winner position: the beat position equals the pre-increment count, and
    // freezes at MAX_LEN-1 once the frame has overflowed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_r <= {IDX_W{1'b0}};
        end else if (start_s) begin
            idx_r <= {IDX_W{1'b0}};
        end else if (accept_s && replace_s) begin
            idx_r <= cnt_full_s ? IDX_LAST : count_r[IDX_W-1:0];
        end
    end

    assign bus.out_idx = idx_r;
`else
    assign bus.out_idx = {IDX_W{1'b0}};
`endif

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_s;
    assign bus.out_data  = acc_r;
    assign bus.out_count = count_r;
    assign bus.out_ovf   = ovf_r;

endmodule

// File: tb/tb_cpuc_cmp_reduce.sv
// ---------------------------------------------------------------------------
// tb_cpuc_cmp_reduce
// Directed bench for cpuc_cmp_reduce. Three instances share one stimulus:
//   dut_s : SIGNED_CMP=1, MAX_LEN=256
//   dut_u : SIGNED_CMP=0, MAX_LEN=256
//   dut_4 : SIGNED_CMP=1, MAX_LEN=4
// Their control flow is data-independent, so they stay in lock-step and each
// scenario is checked on the instance whose configuration it targets.
// ---------------------------------------------------------------------------
module tb_cpuc_cmp_reduce;
    logic        clk;
    logic        rst_n;
    logic        mode_min;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_last;
    logic        out_ready;

    int checks_cnt;
    int errors_cnt;

    cpuc_cmp_reduce_if #(.DATA_WIDTH(32), .IDX_W(8)) if_s ();
    cpuc_cmp_reduce_if #(.DATA_WIDTH(32), .IDX_W(8)) if_u ();
    cpuc_cmp_reduce_if #(.DATA_WIDTH(32), .IDX_W(2)) if_4 ();

    assign if_s.mode_min  = mode_min;
    assign if_s.in_valid  = in_valid;
    assign if_s.in_data   = in_data;
    assign if_s.in_last   = in_last;
    assign if_s.out_ready = out_ready;
    assign if_u.mode_min  = mode_min;
    assign if_u.in_valid  = in_valid;
    assign if_u.in_data   = in_data;
    assign if_u.in_last   = in_last;
    assign if_u.out_ready = out_ready;
    assign if_4.mode_min  = mode_min;
    assign if_4.in_valid  = in_valid;
    assign if_4.in_data   = in_data;
    assign if_4.in_last   = in_last;
    assign if_4.out_ready = out_ready;

    cpuc_cmp_reduce #(.DATA_WIDTH(32), .SIGNED_CMP(1), .MAX_LEN(256)) dut_s (
        .clk(clk), .rst_n(rst_n), .bus(if_s)
    );
    cpuc_cmp_reduce #(.DATA_WIDTH(32), .SIGNED_CMP(0), .MAX_LEN(256)) dut_u (
        .clk(clk), .rst_n(rst_n), .bus(if_u)
    );
    cpuc_cmp_reduce #(.DATA_WIDTH(32), .SIGNED_CMP(1), .MAX_LEN(4)) dut_4 (
        .clk(clk), .rst_n(rst_n), .bus(if_4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected out_idx: the winner position when the index logic is built, else 0.
    function automatic logic [63:0] exp_idx(input int pos);
`ifdef CPUC_CMP_IDX_EN
        return 64'(pos);
`else
        return 64'(pos) & 64'h0;
`endif
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks_cnt = checks_cnt + 1;
        if (got !== exp) begin
            errors_cnt = errors_cnt + 1;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Present one beat, let it be accepted on the next edge, sample #1 later.
    task automatic send(input logic [31:0] data, input logic last, input logic mode);
        in_valid = 1'b1;
        in_data  = data;
        in_last  = last;
        mode_min = mode;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks_cnt = 0;
        errors_cnt = 0;
        rst_n      = 1'b0;
        mode_min   = 1'b0;
        in_valid   = 1'b0;
        in_data    = 32'd0;
        in_last    = 1'b0;
        out_ready  = 1'b1;

        // Reset state
        #12;
        check_eq("rst_out_valid", 64'(if_s.out_valid), 64'd0);
        check_eq("rst_in_ready",  64'(if_s.in_ready),  64'd1);
        check_eq("rst_out_data",  64'(if_s.out_data),  64'd0);
        check_eq("rst_out_count", 64'(if_s.out_count), 64'd0);
        check_eq("rst_out_ovf",   64'(if_s.out_ovf),   64'd0);
        check_eq("rst_out_idx",   64'(if_s.out_idx),   64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: signed max {5,-3,9,9,2}: tie on 9 keeps index 2
        send(32'd5, 1'b0, 1'b0);
        send(32'hFFFF_FFFD, 1'b0, 1'b0);
        send(32'd9, 1'b0, 1'b0);
        send(32'd9, 1'b0, 1'b0);
        check_eq("s1_valid_early", 64'(if_s.out_valid), 64'd0);
        send(32'd2, 1'b1, 1'b0);
        check_eq("s1_valid",  64'(if_s.out_valid), 64'd1);
        check_eq("s1_data",   64'(if_s.out_data),  64'd9);
        check_eq("s1_idx",    64'(if_s.out_idx),   exp_idx(2));
        check_eq("s1_count",  64'(if_s.out_count), 64'd5);
        check_eq("s1_ovf",    64'(if_s.out_ovf),   64'd0);
        idle_cycle();
        check_eq("s1_taken",  64'(if_s.out_valid), 64'd0);

        // 2: min {0x10,0xFFFFFFFF,0x03}, unsigned vs signed compare
        send(32'h10, 1'b0, 1'b1);
        send(32'hFFFF_FFFF, 1'b0, 1'b1);
        send(32'h03, 1'b1, 1'b1);
        check_eq("s2_u_data", 64'(if_u.out_data), 64'h3);
        check_eq("s2_u_idx",  64'(if_u.out_idx),  exp_idx(2));
        check_eq("s2_s_data", 64'(if_s.out_data), 64'hFFFF_FFFF);
        check_eq("s2_s_idx",  64'(if_s.out_idx),  exp_idx(1));
        idle_cycle();

        // 3: back-to-back frames {1,7} then {4}, no bubble
        send(32'd1, 1'b0, 1'b0);
        check_eq("s3_ready0", 64'(if_s.in_ready), 64'd1);
        send(32'd7, 1'b1, 1'b0);
        check_eq("s3_r1_valid", 64'(if_s.out_valid), 64'd1);
        check_eq("s3_r1_data",  64'(if_s.out_data),  64'd7);
        check_eq("s3_ready1",   64'(if_s.in_ready),  64'd1);
        send(32'd4, 1'b1, 1'b0);
        check_eq("s3_r2_valid", 64'(if_s.out_valid), 64'd1);
        check_eq("s3_r2_data",  64'(if_s.out_data),  64'd4);
        check_eq("s3_r2_count", 64'(if_s.out_count), 64'd1);
        // Back-pressure: consumer stalls 3 cycles while a new beat is offered
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'd99;
        in_last   = 1'b1;
        mode_min  = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check_eq("s3_bp_ready", 64'(if_s.in_ready),  64'd0);
            check_eq("s3_bp_valid", 64'(if_s.out_valid), 64'd1);
            check_eq("s3_bp_data",  64'(if_s.out_data),  64'd4);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        check_eq("s3_next_data",  64'(if_s.out_data),  64'd99);
        check_eq("s3_next_valid", 64'(if_s.out_valid), 64'd1);
        idle_cycle();

        // 4: MAX_LEN=4 with a 6-beat frame overflows and saturates
        for (int i = 1; i <= 6; i++) begin
            send(32'(i), (i == 6) ? 1'b1 : 1'b0, 1'b0);
        end
        check_eq("s4_count", 64'(if_4.out_count), 64'd4);
        check_eq("s4_ovf",   64'(if_4.out_ovf),   64'd1);
        check_eq("s4_data",  64'(if_4.out_data),  64'd6);
        check_eq("s4_idx",   64'(if_4.out_idx),   exp_idx(3));
        check_eq("s4_big_count", 64'(if_s.out_count), 64'd6);
        check_eq("s4_big_ovf",   64'(if_s.out_ovf),   64'd0);
        idle_cycle();
        send(32'd8, 1'b1, 1'b0);
        check_eq("s4n_ovf",   64'(if_4.out_ovf),   64'd0);
        check_eq("s4n_count", 64'(if_4.out_count), 64'd1);
        check_eq("s4n_data",  64'(if_4.out_data),  64'd8);
        idle_cycle();

        // 5: reset after beat 2 of a 4-beat frame discards it
        send(32'd10, 1'b0, 1'b0);
        send(32'd20, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check_eq("s5_valid", 64'(if_s.out_valid), 64'd0);
        check_eq("s5_data",  64'(if_s.out_data),  64'd0);
        check_eq("s5_count", 64'(if_s.out_count), 64'd0);
        check_eq("s5_ready", 64'(if_s.in_ready),  64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycle();
        idle_cycle();
        check_eq("s5_no_result", 64'(if_s.out_valid), 64'd0);
        send(32'd42, 1'b1, 1'b0);
        check_eq("s5_new_valid", 64'(if_s.out_valid), 64'd1);
        check_eq("s5_new_data",  64'(if_s.out_data),  64'd42);
        check_eq("s5_new_idx",   64'(if_s.out_idx),   exp_idx(0));
        idle_cycle();

        // 6: mode_min toggled mid-frame is ignored
        send(32'd3, 1'b0, 1'b0);
        send(32'd1, 1'b0, 1'b1);
        send(32'd5, 1'b1, 1'b1);
        check_eq("s6_data",  64'(if_s.out_data),  64'd5);
        check_eq("s6_idx",   64'(if_s.out_idx),   exp_idx(2));
        check_eq("s6_count", 64'(if_s.out_count), 64'd3);
        idle_cycle();
        check_eq("s6_idle", 64'(if_s.out_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end
endmodule
